// File: rtl/reg_op_sequencer_pkg.sv
// Shared definitions for the register-operation sequencer and the 4-bit
// register stage it drives: op codes, FSM state encoding, command layout.
package reg_op_sequencer_pkg;

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_COMP  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] data;
        logic [1:0] rpt;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Parallel data presented downstream: only a load carries its payload.
    function automatic logic [3:0] issue_data(input cmd_t c);
        return (c.op == OP_LOAD) ? c.data : 4'b0000;
    endfunction

endpackage

// File: rtl/reg_op_sequencer_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of two), wrapping pointers, occupancy
// count, head visible combinationally so the sequencer can pop and use it
// in the same cycle. Flush empties the FIFO and overrides push/pop.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == LVL_W'(DEPTH));
    assign empty   = (level_reg == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr_reg];
    assign level   = level_reg;

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/reg_op_sequencer.sv
// Queues register-operation commands and issues each one to the downstream
// 4-bit register stage for rpt+1 cycles, back-to-back with no idle gaps.
module reg_op_sequencer
    import reg_op_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [3:0]             cmd_data,
    input  logic [1:0]             cmd_rpt,
    input  logic                   flush,
    output logic [1:0]             S,
    output logic [3:0]             I,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] level
);

    state_t           state_reg, state_next;
    logic [1:0]       cnt_reg, cnt_next;
    logic [1:0]       s_reg, s_next;
    logic [3:0]       i_reg, i_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             load_head;
    logic             pop;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] head_bits;
    cmd_t             head_cmd;
    cmd_t             wr_cmd;

    assign cmd_ready = !fifo_full && !flush;
    assign push      = cmd_valid && cmd_ready;
    assign wr_cmd    = '{op: cmd_op, data: cmd_data, rpt: cmd_rpt};
    assign head_cmd  = cmd_t'(head_bits);

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wr_cmd),
        .rdata (head_bits),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next state and next registered outputs; a final issue cycle chains
    // straight into the next queued command when one is waiting.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        s_next     = s_reg;
        i_next     = i_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        load_head  = 1'b0;
        pop        = 1'b0;
        if (flush) begin
            state_next = ST_IDLE;
            cnt_next   = 2'd0;
            s_next     = OP_HOLD;
            i_next     = 4'b0000;
            busy_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) load_head = 1'b1;
                end
                ST_ISSUE: begin
                    if (cnt_reg != 2'd0) begin
                        cnt_next  = cnt_reg - 2'd1;
                        done_next = (cnt_reg == 2'd1);
                    end else if (!fifo_empty) begin
                        load_head = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        s_next     = OP_HOLD;
                        i_next     = 4'b0000;
                        busy_next  = 1'b0;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
            if (load_head) begin
                pop        = 1'b1;
                state_next = ST_ISSUE;
                s_next     = head_cmd.op;
                i_next     = issue_data(head_cmd);
                cnt_next   = head_cmd.rpt;
                busy_next  = 1'b1;
                done_next  = (head_cmd.rpt == 2'd0);
            end
        end
    end

    // State, repeat counter and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 2'd0;
            s_reg     <= OP_HOLD;
            i_reg     <= 4'b0000;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            s_reg     <= s_next;
            i_reg     <= i_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign S    = s_reg;
    assign I    = i_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Self-checking bench for reg_op_sequencer: directed scenarios plus a random
// push/flush stream, all compared every cycle against a queue-based model.
module tb_reg_op_sequencer;
    import reg_op_sequencer_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [1:0] cmd_rpt;
    logic       flush;
    logic [1:0] S;
    logic [3:0] I;
    logic       busy;
    logic       done;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    // Reference model: pending queue plus the command currently issuing.
    cmd_t q[$];
    bit   cur_act = 1'b0;
    cmd_t cur;
    int   rem = 0;

    // Downstream 4-bit register stage fed by S/I.
    logic [3:0] dreg = 4'd0;

    reg_op_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_rpt   (cmd_rpt),
        .flush     (flush),
        .S         (S),
        .I         (I),
        .busy      (busy),
        .done      (done),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Downstream register reacting to the operation currently driven.
    always_ff @(posedge clk) begin
        case (S)
            OP_CLEAR: dreg <= 4'd0;
            OP_COMP:  dreg <= ~dreg;
            OP_LOAD:  dreg <= I;
            default:  dreg <= dreg;
        endcase
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic cmd_t mk(input logic [1:0] op, input logic [3:0] d, input logic [1:0] r);
        cmd_t c;
        c.op = op;
        c.data = d;
        c.rpt = r;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the specified behaviour, in queue terms.
    task automatic model_edge(input bit v, input cmd_t c, input bit fl);
        int pre;
        if (fl) begin
            q.delete();
            cur_act = 1'b0;
        end else begin
            pre = q.size();
            if (cur_act && rem > 0) begin
                rem--;
            end else if (pre > 0) begin
                cur = q.pop_front();
                cur_act = 1'b1;
                rem = int'(cur.rpt);
            end else begin
                cur_act = 1'b0;
            end
            if (v && pre < DEPTH) q.push_back(c);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [1:0] es;
        logic [3:0] ei;
        es = cur_act ? cur.op : 2'b00;
        ei = (cur_act && cur.op == OP_LOAD) ? cur.data : 4'b0000;
        chk({tag, "_S"}, 32'(S), 32'(es));
        chk({tag, "_I"}, 32'(I), 32'(ei));
        chk({tag, "_busy"}, 32'(busy), 32'(cur_act));
        chk({tag, "_done"}, 32'(done), 32'(cur_act && rem == 0));
        chk({tag, "_level"}, 32'(level), 32'(q.size()));
    endtask

    // Entered and left at posedge+1: drive, check ready, clock, check outputs.
    task automatic step(input string tag, input bit v, input cmd_t c, input bit fl, output bit acc);
        bit exp_ready;
        cmd_valid = v;
        cmd_op    = c.op;
        cmd_data  = c.data;
        cmd_rpt   = c.rpt;
        flush     = fl;
        #3;
        exp_ready = (q.size() < DEPTH) && !fl;
        chk({tag, "_ready"}, 32'(cmd_ready), 32'(exp_ready));
        acc = v && exp_ready;
        @(posedge clk);
        model_edge(v, c, fl);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n, output int done_seen);
        bit a;
        done_seen = 0;
        for (int k = 0; k < n; k++) begin
            step(tag, 1'b0, mk(2'b00, 4'h0, 2'd0), 1'b0, a);
            if (done === 1'b1) done_seen++;
        end
    endtask

    task automatic drain(input string tag);
        bit a;
        int guard;
        guard = 0;
        while ((q.size() != 0 || cur_act) && guard < 60) begin
            step(tag, 1'b0, mk(2'b00, 4'h0, 2'd0), 1'b0, a);
            guard++;
        end
        chk({tag, "_drained"}, 32'(q.size() == 0 && !cur_act), 32'd1);
    endtask

    initial begin
        bit   acc;
        int   nd;
        int   guard;
        cmd_t c;

        rstn = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_data = 4'h0;
        cmd_rpt = 2'd0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_I", 32'(I), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        rstn = 1'b1;

        // Single load, one cycle; first push right after reset release.
        step("s034_push", 1'b1, mk(OP_LOAD, 4'hA, 2'd0), 1'b0, acc);
        chk("s034_lat_S", 32'(S), 32'(OP_HOLD));
        idle("s034_issue", 1, nd);
        chk("s034_S", 32'(S), 32'(OP_LOAD));
        chk("s034_I", 32'(I), 32'hA);
        chk("s034_done", 32'(done), 32'd1);
        idle("s034_after", 1, nd);
        chk("s034_after_S", 32'(S), 32'(OP_HOLD));

        // Complement four times: downstream register returns to 1010.
        step("s035_push", 1'b1, mk(OP_COMP, 4'h6, 2'd3), 1'b0, acc);
        idle("s035_issue", 5, nd);
        chk("s035_done_count", 32'(nd), 32'd1);
        chk("s035_dreg", 32'(dreg), 32'hA);

        // Five pushes while the first issues; ready must drop at level 4.
        step("s036_c0", 1'b1, mk(OP_LOAD, 4'h1, 2'd3), 1'b0, acc);
        for (int k = 1; k <= 4; k++) begin
            step("s036_ck", 1'b1, mk(OP_LOAD, 4'(k + 1), 2'(k % 2)), 1'b0, acc);
        end
        cmd_valid = 1'b1;
        chk("s036_level_full", 32'(level), 32'd4);
        chk("s036_ready_full", 32'(cmd_ready), 32'd0);
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 10) begin
            step("s036_c5", 1'b1, mk(OP_LOAD, 4'h7, 2'd0), 1'b0, acc);
            guard++;
        end
        chk("s036_c5_accepted", 32'(acc), 32'd1);
        drain("s036_drain");

        // Flush during the second repeat with two commands queued.
        step("s037_x", 1'b1, mk(OP_CLEAR, 4'h0, 2'd3), 1'b0, acc);
        step("s037_q1", 1'b1, mk(OP_LOAD, 4'h7, 2'd0), 1'b0, acc);
        step("s037_q2", 1'b1, mk(OP_LOAD, 4'h9, 2'd1), 1'b0, acc);
        step("s037_flush", 1'b0, mk(OP_HOLD, 4'h0, 2'd0), 1'b1, acc);
        chk("s037_S", 32'(S), 32'(OP_HOLD));
        chk("s037_level", 32'(level), 32'd0);
        idle("s037_after", 6, nd);
        chk("s037_done_count", 32'(nd), 32'd0);

        // Asynchronous reset in the middle of an issue.
        step("s038_a", 1'b1, mk(OP_COMP, 4'h3, 2'd3), 1'b0, acc);
        step("s038_b", 1'b1, mk(OP_LOAD, 4'h5, 2'd2), 1'b0, acc);
        idle("s038_run", 1, nd);
        #2;
        rstn = 1'b0;
        #1;
        chk("s038_S", 32'(S), 32'd0);
        chk("s038_I", 32'(I), 32'd0);
        chk("s038_busy", 32'(busy), 32'd0);
        chk("s038_done", 32'(done), 32'd0);
        chk("s038_level", 32'(level), 32'd0);
        q.delete();
        cur_act = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step("s038_first", 1'b1, mk(OP_LOAD, 4'hC, 2'd1), 1'b0, acc);
        drain("s038_drain");

        // Random push/flush stream against the model.
        for (int k = 0; k < 400; k++) begin
            c = mk(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            step("rand", ($urandom_range(0, 99) < 60), c, ($urandom_range(0, 99) < 4), acc);
        end
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_op_sequencer.md
REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, meaning command FIFO depth in entries (power of two, minimum 2).
REQ-002 clk  input  1  meaning sole clock; every state element updates on its rising edge.
REQ-003 rstn  input  1  meaning asynchronous active-low reset.
REQ-004 cmd_valid  input  1  meaning upstream offers a command this cycle.
REQ-005 cmd_ready  output  1  meaning block accepts a command this cycle; push occurs when cmd_valid and cmd_ready are both high at a rising edge.
REQ-006 cmd_op  input  2  meaning register operation code: 00 hold, 01 clear, 10 complement, 11 load.
REQ-007 cmd_data  input  4  meaning load value, used only when cmd_op=11.
REQ-008 cmd_rpt  input  2  meaning repeat count; the command is issued for cmd_rpt+1 cycles (1..4).
REQ-009 flush  input  1  meaning synchronous abort of the queued commands and the current command.
REQ-010 S  output  2  meaning operation select driven to the downstream 4-bit register stage.
REQ-011 I  output  4  meaning parallel data driven to the downstream register stage.
REQ-012 busy  output  1  meaning a command is currently being issued.
REQ-013 done  output  1  meaning one-cycle pulse on the final issue cycle of each command.
REQ-014 level  output  $clog2(DEPTH)+1  meaning number of queued, not-yet-issued commands.

Function
REQ-015 Commands shall be stored as {op, data, rpt} in a FIFO of DEPTH entries, in first-in first-out order.
REQ-016 cmd_ready shall be 1 when level<DEPTH and flush=0, and 0 otherwise; cmd_ready shall be combinational from level and flush.
REQ-017 The FSM shall have two states: IDLE and ISSUE.
REQ-018 IDLE with level>0: at the next edge, pop the head, load S/I from it, load the repeat counter with rpt, and go to ISSUE.
REQ-019 ISSUE with counter>0: decrement the counter and hold S/I.
REQ-020 ISSUE with counter=0 (final cycle, done=1): if level>0, pop the next command back-to-back with no hold gap; otherwise go to IDLE.
REQ-021 S, I, busy and done shall be registered outputs; in IDLE, S=00, I=0000, busy=0 and done=0.
REQ-022 I shall equal the command's data when op=11, and 0000 for all other ops.
REQ-023 Latency: a command pushed into an empty FIFO while in IDLE at edge t shall appear on S/I after edge t+1.
REQ-024 A simultaneous push and pop shall leave level unchanged; a push is permitted on a full-FIFO cycle only if cmd_ready=1, so no push can occur when full.
REQ-025 Pointers shall wrap modulo DEPTH, and level shall saturate at neither bound through misuse: push is blocked when full, and pop is blocked when empty.
REQ-026 flush=1 at an edge shall empty the FIFO (level=0), force IDLE, and drive S=00, I=0000, busy=0, done=0 after that edge.
REQ-027 flush shall take priority over both push and pop; no command is lost silently because cmd_ready=0 while flush=1.
REQ-028 An op=00 command shall still occupy issue cycles and pulse done.

Reset
REQ-029 rstn low shall asynchronously clear the FIFO pointers and level, set the FSM to IDLE, and set S=00, I=0000, busy=0, done=0.
REQ-030 Reset asserted mid-command shall discard the remaining repeats and all queued commands.
REQ-031 Reset release shall be synchronous to clk, and the first push is accepted at the first edge after rstn goes high.

Structure
REQ-032 Op-code constants (OP_HOLD, OP_CLEAR, OP_COMP, OP_LOAD) and the FSM state encoding shall reside in a shared package, which the register stage also uses.
REQ-033 The FIFO shall be a separate sub-module, cmd_fifo, parameterised by DEPTH and width; the FSM and output registers shall be in reg_op_sequencer.

Verification
REQ-034 Scenario: reset, then push {11,1010,rpt=0} -> S=11 and I=1010 for exactly one cycle, done=1 in that cycle, then S=00.
REQ-035 Scenario: push {10,xxxx,rpt=3} -> S=10 for 4 consecutive cycles with I=0000, done only on the 4th cycle; a downstream register holding 1010 ends at 1010.
REQ-036 Scenario: push 5 commands back-to-back with DEPTH=4 while the first is issuing -> cmd_ready drops when level=4, no command is dropped, issue order matches push order, and there are no idle gaps between commands.
REQ-037 Scenario: flush during the 2nd repeat of {01,rpt=3} with 2 commands queued -> S=00 after the next edge, level=0, and no further done pulses.
REQ-038 Scenario: assert rstn=0 mid-ISSUE between edges -> outputs go to their reset values immediately, before the next clk edge.
REQ-039 Scenario: random push/flush stream against a reference queue model -> S/I issue sequence and level match every cycle.
